// File: rtl/fpmul_pkg.sv
// Shared types and constants for the FP multiplier operand loader.
package fpmul_pkg;

   localparam int OP_W        = 32;  // single-precision operand width
   localparam int FRAME_BYTES = 8;   // two operands, MSB-first bytes

   typedef enum logic {
      COLLECT = 1'b0,
      ISSUE   = 1'b1
   } state_e;

   // Width of an idle counter that must be able to hold the value 'cycles'.
   function automatic int tmo_w(input int cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/fpmul_pin_sync.sv
// Single-bit pad synchroniser with a registered previous value, giving a
// clean level and a one-cycle rising-edge pulse in the wb_clk_i domain.
module fpmul_pin_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic pin_i,
   output logic level_o,
   output logic rise_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   // Shift the pad through the flop chain and remember last synced level.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], pin_i};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign level_o = sync_q[STAGES-1];
   assign rise_o  = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/fpmul_operand_loader.sv
// Collects eight MSB-first bytes from an asynchronous pad bus into two
// single-precision operands and hands them to the multiplier over
// valid/ready. Reports frame progress and a sticky error flag.
module fpmul_operand_loader
   import fpmul_pkg::*;
#(
   parameter int OP_W           = fpmul_pkg::OP_W,
   parameter int BYTE_W         = 8,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic [BYTE_W-1:0] pin_data_i,
   input  logic              pin_strobe_i,
   input  logic              pin_frame_i,
   output logic [OP_W-1:0]   op_a_o,
   output logic [OP_W-1:0]   op_b_o,
   output logic              op_valid_o,
   input  logic              op_ready_i,
   output logic              busy_o,
   output logic [2:0]        byte_cnt_o,
   output logic              frame_err_o
);

   localparam int FRAME_W = 2 * OP_W;
   localparam int TMO_W   = tmo_w(TIMEOUT_CYCLES);

   logic [SYNC_STAGES-1:0][BYTE_W-1:0] data_sync_q;
   logic [BYTE_W-1:0]                  data_s;
   logic                               strobe_rise, frame_rise;
   logic                               strobe_lvl_unused, frame_lvl_unused;

   state_e             state_q;
   logic [2:0]         idx_q;
   logic [FRAME_W-1:0] frame_q;
   logic [TMO_W-1:0]   tmo_q;
   logic [OP_W-1:0]    op_a_q, op_b_q;
   logic               op_valid_q;
   logic               err_q;

   // Data bus synchroniser, same depth as the strobe so both line up.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) data_sync_q <= '0;
      else          data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], pin_data_i};
   end

   assign data_s = data_sync_q[SYNC_STAGES-1];

   fpmul_pin_sync #(.STAGES(SYNC_STAGES)) u_strobe_sync (
      .clk_i   (wb_clk_i),
      .rst_i   (wb_rst_i),
      .pin_i   (pin_strobe_i),
      .level_o (strobe_lvl_unused),
      .rise_o  (strobe_rise)
   );

   fpmul_pin_sync #(.STAGES(SYNC_STAGES)) u_frame_sync (
      .clk_i   (wb_clk_i),
      .rst_i   (wb_rst_i),
      .pin_i   (pin_frame_i),
      .level_o (frame_lvl_unused),
      .rise_o  (frame_rise)
   );

   // Frame assembly, timeout, handshake and error tracking FSM.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q    <= COLLECT;
         idx_q      <= '0;
         frame_q    <= '0;
         tmo_q      <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         op_valid_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         case (state_q)
            COLLECT: begin
               if (frame_rise) begin
                  // Resync wins over a coincident strobe; that byte is lost.
                  idx_q   <= '0;
                  frame_q <= '0;
                  tmo_q   <= '0;
                  if (idx_q != 3'd0) err_q <= 1'b1;
               end else if (strobe_rise) begin
                  frame_q <= {frame_q[FRAME_W-BYTE_W-1:0], data_s};
                  tmo_q   <= '0;
                  if (idx_q == 3'(FRAME_BYTES - 1)) begin
                     // Bytes 0..6 already sit in the low 56 bits.
                     op_a_q  <= frame_q[FRAME_W-BYTE_W-1 -: OP_W];
                     op_b_q  <= {frame_q[OP_W-BYTE_W-1:0], data_s};
                     idx_q   <= '0;
                     state_q <= ISSUE;
                  end else begin
                     idx_q <= idx_q + 3'd1;
                  end
               end else if (idx_q != 3'd0) begin
                  // Abandon a stalled partial frame.
                  if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                     idx_q <= '0;
                     err_q <= 1'b1;
                     tmo_q <= '0;
                  end else begin
                     tmo_q <= tmo_q + 1'b1;
                  end
               end
            end
            ISSUE: begin
               // Host overran the multiplier: drop the byte, flag it.
               if (strobe_rise) err_q <= 1'b1;
               // Valid rises one clock after entering ISSUE.
               if (op_valid_q && op_ready_i) begin
                  op_valid_q <= 1'b0;
                  state_q    <= COLLECT;
               end else begin
                  op_valid_q <= 1'b1;
               end
            end
            default: state_q <= COLLECT;
         endcase
      end
   end

   assign op_a_o      = op_a_q;
   assign op_b_o      = op_b_q;
   assign op_valid_o  = op_valid_q;
   assign byte_cnt_o  = idx_q;
   assign frame_err_o = err_q;
   assign busy_o      = (state_q == ISSUE) || (idx_q != 3'd0);

endmodule

// File: doc/fpmul_operand_loader.md
Name: fpmul_operand_loader

Overview:
Upstream front end of the FP multiplier. It collects two IEEE-754 single-precision operands from an 8-bit pad-driven byte bus, strobed asynchronously by an external host. It assembles them into a 64-bit frame and presents them to the multiplier core through a valid/ready handshake. It also reports progress and error status for io_out status pins.

Parameters:
OP_W, 32, operand width in bits (fixed for single precision)
BYTE_W, 8, pad byte-bus width
SYNC_STAGES, 2, flops in each pad synchroniser (minimum 2)
TIMEOUT_CYCLES, 1024, idle clocks after which a partial frame is abandoned

Ports:
wb_clk_i  in  1  sole clock
wb_rst_i  in  1  reset, synchronous, active-high
pin_data_i  in  8  byte from pads (asynchronous)
pin_strobe_i  in  1  byte strobe from pads (asynchronous); byte accepted on rising edge
pin_frame_i  in  1  frame-resync from pads (asynchronous); rising edge restarts frame
op_a_o  out  32  operand A to multiplier
op_b_o  out  32  operand B to multiplier
op_valid_o  out  1  operands valid
op_ready_i  in  1  multiplier accepts operands
busy_o  out  1  frame in progress or awaiting handshake
byte_cnt_o  out  3  bytes collected in current frame (0..7)
frame_err_o  out  1  sticky error flag

Behaviour:
- Reset (synchronous, wb_rst_i high at a clock edge): all outputs 0, state COLLECT, idx 0, synchronisers cleared, timeout counter 0. Reset mid-frame or mid-handshake discards everything.
- pin_data_i, pin_strobe_i and pin_frame_i each pass through SYNC_STAGES flops.
- Edge detect: edge = sync_out & ~prev.
- Byte capture uses the synchronised data on the strobe-edge cycle. The host must hold data stable from 1 clock before to SYNC_STAGES+1 clocks after the strobe rise.
- Byte order is MSB first:
  - bytes 0..3 form A[31:24], A[23:16], A[15:8], A[7:0];
  - bytes 4..7 form B in the same order.
- COLLECT state:
  - On a strobe edge, shift the byte into the 64-bit frame register, idx+1, clear the timeout counter.
  - On byte 7, latch the frame into op_a_o/op_b_o, idx to 0, go to ISSUE.
  - op_valid_o rises on the next clock, SYNC_STAGES+1 clocks after the first edge that samples the strobe high.
- ISSUE state:
  - op_valid_o is held high; op_a_o/op_b_o are stable.
  - Transfer happens at a clock edge with op_valid_o && op_ready_i. op_valid_o is 0 the next cycle; state returns to COLLECT.
  - op_ready_i may be high before valid; a transfer then takes exactly one cycle of valid.
- Operand outputs hold their last value after transfer. They change only at frame completion.
- Strobe edge during ISSUE: byte dropped, frame_err_o set.
- Frame edge:
  - In COLLECT, idx goes to 0 and the shift register is cleared. frame_err_o is set if idx was nonzero.
  - In ISSUE, the edge is ignored.
- Frame edge and strobe edge in the same cycle: frame wins; the byte is dropped without error and idx ends at 0.
- Timeout:
  - In COLLECT with idx != 0, count clocks since the last byte.
  - On reaching TIMEOUT_CYCLES, set idx to 0 and frame_err_o, clear the counter.
  - The counter does not run when idx = 0 or in ISSUE.
- frame_err_o is sticky; only reset clears it.
- busy_o = (state == ISSUE) || (idx != 0).
- byte_cnt_o = idx (registered).

Decomposition:
- Package fpmul_pkg holds:
  - state enum {COLLECT, ISSUE};
  - FRAME_BYTES = 8;
  - OP_W = 32;
  - timeout counter width = $clog2(TIMEOUT_CYCLES+1).
- One sub-module, fpmul_pin_sync: SYNC_STAGES-deep synchroniser with a registered prev value, outputs level and rise.
  - Instantiated for strobe and frame.
  - pin_data_i uses a plain vector synchroniser of the same depth.

Test Plan:
- Normal frame: bytes 3F C0 00 00 C0 00 00 00, op_ready_i=1 → op_a_o=0x3FC00000, op_b_o=0xC0000000; op_valid_o high exactly 1 cycle, rising SYNC_STAGES+1 clocks after the 8th strobe; byte_cnt_o returns to 0.
- Backpressure: same frame, op_ready_i=0 for 10 clocks then 1 → op_valid_o high 11 cycles with operands unchanged; busy_o=1 throughout, 0 after transfer.
- Overrun: 9th strobe (data 0xAA) while in ISSUE → byte dropped, frame_err_o=1; op_a_o/op_b_o unchanged; next frame 40 49 0F DB 3F 80 00 00 → op_a_o=0x40490FDB, op_b_o=0x3F800000.
- Timeout (TIMEOUT_CYCLES=16): 3 bytes then 16 idle clocks → byte_cnt_o 3→0, frame_err_o=1; no op_valid_o.
- Resync: 5 bytes, then a pin_frame_i pulse, then a full 8-byte frame → frame_err_o=1; operands equal the 8 post-resync bytes. Frame pulse with idx=0 → no error.
- Reset mid-frame: 4 bytes, wb_rst_i high 1 clock, then a full frame → all outputs 0 after reset; result reflects only the post-reset frame.
